ahbl_splitter: RTL and testbench
================================

# ahbl_splitter

Strict 1:N AHB-Lite address decoder/splitter: one upstream master port fans out to N downstream slave ports, selected by per-port address match/mask. It is the fabric counterpart of the N:1 arbiter; a splitter behind an arbiter forms a crossbar leg. It registers the data-phase slave select, muxes responses back, and contains a built-in default slave that returns a two-cycle ERROR for unmapped active transfers. It adds no wait states to mapped transfers.

## Interface
- `N_PORTS`, 2: number of downstream slaves.
- `W_ADDR`, 32: address width.
- `W_DATA`, 32: data width.
- `ADDR_MAP`, {32'h2000_0000, 32'h0000_0000}: N_PORTS×W_ADDR concat; port i base.
- `ADDR_MASK`, {32'hf000_0000, 32'hf000_0000}: N_PORTS×W_ADDR concat; port i match mask.
- `CONN_MASK`, {N_PORTS{1'b1}}: port i decodable only if bit set.
- `clk` in 1: clock.
- `rst_n` in 1: reset; one clock; reset is asynchronous and active-low.
- `src_hready` in 1: bus HREADY seen by the upstream master.
- `src_hready_resp` out 1, `src_hresp` out 1, `src_hrdata` out W_DATA: upstream response.
- `src_haddr` in W_ADDR; `src_hwrite` in 1; `src_htrans` in 2; `src_hsize` in 3; `src_hburst` in 3; `src_hprot` in 4; `src_hmastlock` in 1; `src_hwdata` in W_DATA: upstream request.
- `dst_hready` out N_PORTS: HREADY to each slave.
- `dst_hready_resp` in N_PORTS, `dst_hresp` in N_PORTS, `dst_hrdata` in N_PORTS×W_DATA: per-slave responses.
- `dst_haddr` out N_PORTS×W_ADDR, `dst_hwrite` out N_PORTS, `dst_htrans` out N_PORTS×2, `dst_hsize` out N_PORTS×3, `dst_hburst` out N_PORTS×3, `dst_hprot` out N_PORTS×4, `dst_hmastlock` out N_PORTS, `dst_hwdata` out N_PORTS×W_DATA: per-slave request signals.

## Operation
- Decode (combinational): `match[i] = ((src_haddr & ADDR_MASK[i]) == ADDR_MAP[i]) && CONN_MASK[i]`. Multiple matches are resolved by priority: the lowest index wins, giving one-hot `sel_a`.
- `active = src_htrans[1]` (NONSEQ/SEQ). `err_a = active && !(|match)`.
- Request fan-out:
  - haddr, hwrite, hsize, hburst, hprot, hmastlock and hwdata are broadcast unmodified to all ports.
  - `dst_htrans[i] = sel_a[i] ? src_htrans : 2'b00`; unselected slaves always see IDLE.
- `dst_hready[i] = src_hready` for all i.
- Data-phase state, updated only when `src_hready`=1:
  - `sel_d <= active ? sel_a : 0`.
  - Default-slave FSM:
    - IDLE→ERR1 when `err_a`.
    - ERR1→ERR2 unconditionally.
    - ERR2→ERR1 if `src_hready && err_a`; else IDLE.
- Response mux:
  - If `sel_d`≠0: `src_hready_resp`, `src_hresp` and `src_hrdata` are taken from the selected port.
  - ERR1: `src_hready_resp`=0, `src_hresp`=1.
  - ERR2: `src_hready_resp`=1, `src_hresp`=1.
  - Otherwise: `src_hready_resp`=1, `src_hresp`=0.
  - `src_hrdata`=0 whenever `sel_d`=0.
- IDLE/BUSY to an unmapped address: OKAY, zero wait, FSM stays IDLE.

## Timing
- Address phase: zero-cycle combinational decode. Data phase: select registered at the `src_hready` edge, so response latency is exactly the slave's own latency.
- Unmapped active transfer: exactly 2 data-phase cycles (ERR1, ERR2). The next address is accepted on the ERR2 cycle.
- Slave wait states (`dst_hready_resp`=0) hold `sel_d` and the FSM; nothing updates while `src_hready`=0.
- Back-to-back transfers to different slaves: `sel_a` and `sel_d` differ in the same cycle. The new slave sees its address while the old slave completes its data phase.
- Slave ERROR: the slave's two-cycle hresp passes through untouched.
- Reset values (async, immediate, including mid-transfer):
  - `sel_d`=0, FSM=IDLE.
  - `src_hready_resp`=1, `src_hresp`=0, `src_hrdata`=0.
  - `dst_htrans` is purely combinational and follows `src_htrans`.

## Structure
- Shared defines header: HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ) and HRESP OKAY/ERROR. These are already common to the arbiter and are reused here.
- Reuse existing `onehot_priority` for match resolution and `onehot_mux` (W_DATA and 1-bit instances) for response muxing. No new sub-module.
- FSM is a 2-bit local state register.

## Test plan
- Mapped read, default params: NONSEQ read at 32'h2000_0010; slave 1 returns hrdata 32'hdead_beef, zero wait → `dst_htrans[3:2]`=2'b10, `dst_htrans[1:0]`=0; next cycle `src_hrdata`=32'hdead_beef, hready_resp=1.
- Wait states: slave 0 holds hready_resp=0 for 3 cycles on write to 32'h0000_0004 → `src_hready_resp`=0 for 3 cycles; `sel_d` stable; the next address is not decoded until completion.
- Unmapped: NONSEQ to 32'h5000_0000 → `dst_htrans` all 0; data phase gives (hready_resp,hresp)=(0,1) then (1,1).
- Error back-to-back: two NONSEQs to 32'h5000_0000, the second presented during ERR2 → sequence ERR1,ERR2,ERR1,ERR2, then OKAY idle.
- Ping-pong: NONSEQ to slave 0 then to slave 1 on consecutive cycles, both zero wait → data returned from port 0 then port 1 with no bubble.
- Async reset asserted during ERR1 → `src_hready_resp`=1 and `src_hresp`=0 immediately; after release, an IDLE transfer returns OKAY.

Source files
------------

// File: rtl/ahbl_splitter_pkg.sv
// ahbl_splitter_pkg
//   AHB-Lite encodings shared by the fabric blocks (arbiter, splitter),
//   plus the splitter's default-slave state type.
//   No ports; import with "import ahbl_splitter_pkg::*;".
package ahbl_splitter_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Default slave: an unmapped active transfer is answered by ERR1
  // (wait, ERROR) followed by ERR2 (ready, ERROR).
  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } dflt_state_e;

endpackage

// File: rtl/ahbl_splitter_if.sv
// ahbl_splitter_if
//   Bundles the upstream AHB-Lite master port (src_*) and the N downstream
//   slave ports (dst_*, flat concatenations, port i in slice i).
//   modport slave  : the splitter's view (takes src requests, drives dst
//                    requests, collects dst responses, drives src response).
//   modport master : the environment's view (upstream master + slaves).
interface ahbl_splitter_if #(
  parameter int N_PORTS = 2,
  parameter int W_ADDR  = 32,
  parameter int W_DATA  = 32
);

  // Upstream request / bus ready
  logic                      src_hready;
  logic [W_ADDR-1:0]         src_haddr;
  logic                      src_hwrite;
  logic [1:0]                src_htrans;
  logic [2:0]                src_hsize;
  logic [2:0]                src_hburst;
  logic [3:0]                src_hprot;
  logic                      src_hmastlock;
  logic [W_DATA-1:0]         src_hwdata;
  // Upstream response
  logic                      src_hready_resp;
  logic                      src_hresp;
  logic [W_DATA-1:0]         src_hrdata;
  // Downstream requests
  logic [N_PORTS-1:0]        dst_hready;
  logic [N_PORTS*W_ADDR-1:0] dst_haddr;
  logic [N_PORTS-1:0]        dst_hwrite;
  logic [N_PORTS*2-1:0]      dst_htrans;
  logic [N_PORTS*3-1:0]      dst_hsize;
  logic [N_PORTS*3-1:0]      dst_hburst;
  logic [N_PORTS*4-1:0]      dst_hprot;
  logic [N_PORTS-1:0]        dst_hmastlock;
  logic [N_PORTS*W_DATA-1:0] dst_hwdata;
  // Downstream responses
  logic [N_PORTS-1:0]        dst_hready_resp;
  logic [N_PORTS-1:0]        dst_hresp;
  logic [N_PORTS*W_DATA-1:0] dst_hrdata;

  modport slave (
    input  src_hready, src_haddr, src_hwrite, src_htrans, src_hsize,
           src_hburst, src_hprot, src_hmastlock, src_hwdata,
           dst_hready_resp, dst_hresp, dst_hrdata,
    output src_hready_resp, src_hresp, src_hrdata,
           dst_hready, dst_haddr, dst_hwrite, dst_htrans, dst_hsize,
           dst_hburst, dst_hprot, dst_hmastlock, dst_hwdata
  );

  modport master (
    output src_hready, src_haddr, src_hwrite, src_htrans, src_hsize,
           src_hburst, src_hprot, src_hmastlock, src_hwdata,
           dst_hready_resp, dst_hresp, dst_hrdata,
    input  src_hready_resp, src_hresp, src_hrdata,
           dst_hready, dst_haddr, dst_hwrite, dst_htrans, dst_hsize,
           dst_hburst, dst_hprot, dst_hmastlock, dst_hwdata
  );

endinterface

// File: rtl/ahbl_splitter.sv
// ahbl_splitter
//   1:N AHB-Lite address decoder. The address phase is decoded
//   combinationally (lowest matching port wins); the winning select is
//   registered at the src_hready edge so the response of the slave owning
//   the data phase is muxed back with no added wait states. Unmapped active
//   transfers are answered by a built-in two-cycle ERROR default slave.
// Ports
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : ahbl_splitter_if.slave (src_* upstream, dst_* per-slave)
module ahbl_splitter
  import ahbl_splitter_pkg::*;
#(
  parameter int                        N_PORTS   = 2,
  parameter int                        W_ADDR    = 32,
  parameter int                        W_DATA    = 32,
  parameter logic [N_PORTS*W_ADDR-1:0] ADDR_MAP  = {32'h2000_0000, 32'h0000_0000},
  parameter logic [N_PORTS*W_ADDR-1:0] ADDR_MASK = {32'hf000_0000, 32'hf000_0000},
  parameter logic [N_PORTS-1:0]        CONN_MASK = {N_PORTS{1'b1}}
) (
  input  logic            clk,
  input  logic            rst_n,
  ahbl_splitter_if.slave  bus
);

  logic [N_PORTS-1:0] match;
  logic [N_PORTS-1:0] sel_a;
  logic [N_PORTS-1:0] sel_d;
  logic               active;
  logic               err_a;
  dflt_state_e        state;
  dflt_state_e        state_nxt;

  logic               mux_ready;
  logic               mux_resp;
  logic [W_DATA-1:0]  mux_rdata;

  // ---- Address phase: decode ----
  always_comb begin
    match = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      match[i] = ((bus.src_haddr & ADDR_MASK[i*W_ADDR +: W_ADDR])
                  == ADDR_MAP[i*W_ADDR +: W_ADDR]) && CONN_MASK[i];
    end
  end

  // Isolate the lowest set bit: overlapping windows resolve to the
  // lowest-numbered port.
  assign sel_a  = match & (~match + N_PORTS'(1));
  assign active = bus.src_htrans[1];
  assign err_a  = active && !(|match);

  // ---- Address phase: request fan-out ----
  assign bus.dst_hready    = {N_PORTS{bus.src_hready}};
  assign bus.dst_haddr     = {N_PORTS{bus.src_haddr}};
  assign bus.dst_hwrite    = {N_PORTS{bus.src_hwrite}};
  assign bus.dst_hsize     = {N_PORTS{bus.src_hsize}};
  assign bus.dst_hburst    = {N_PORTS{bus.src_hburst}};
  assign bus.dst_hprot     = {N_PORTS{bus.src_hprot}};
  assign bus.dst_hmastlock = {N_PORTS{bus.src_hmastlock}};
  assign bus.dst_hwdata    = {N_PORTS{bus.src_hwdata}};

  // Only the selected slave ever sees a non-IDLE transfer.
  always_comb begin
    bus.dst_htrans = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      bus.dst_htrans[i*2 +: 2] = sel_a[i] ? bus.src_htrans : HTRANS_IDLE;
    end
  end

  // ---- Address/data phase boundary: registered select ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_d <= '0;
    end else if (bus.src_hready) begin
      sel_d <= active ? sel_a : '0;
    end
  end

  // ---- Default slave FSM: state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DS_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---- Default slave FSM: next state ----
  // ERR1 drives hready low itself, so it must advance without waiting for
  // src_hready or the bus would stall forever.
  always_comb begin
    state_nxt = state;
    case (state)
      DS_IDLE: if (bus.src_hready && err_a) state_nxt = DS_ERR1;
      DS_ERR1: state_nxt = DS_ERR2;
      DS_ERR2: state_nxt = (bus.src_hready && err_a) ? DS_ERR1 : DS_IDLE;
      default: state_nxt = DS_IDLE;
    endcase
  end

  // ---- Data phase: response mux (sel_d is one-hot or zero) ----
  always_comb begin
    mux_ready = 1'b0;
    mux_resp  = 1'b0;
    mux_rdata = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      mux_ready = mux_ready | (sel_d[i] & bus.dst_hready_resp[i]);
      mux_resp  = mux_resp  | (sel_d[i] & bus.dst_hresp[i]);
      mux_rdata = mux_rdata | ({W_DATA{sel_d[i]}} & bus.dst_hrdata[i*W_DATA +: W_DATA]);
    end
  end

  // ---- Default slave FSM: outputs / upstream response ----
  always_comb begin
    bus.src_hready_resp = 1'b1;
    bus.src_hresp       = HRESP_OKAY;
    bus.src_hrdata      = '0;
    if (|sel_d) begin
      bus.src_hready_resp = mux_ready;
      bus.src_hresp       = mux_resp;
      bus.src_hrdata      = mux_rdata;
    end else begin
      case (state)
        DS_ERR1: begin
          bus.src_hready_resp = 1'b0;
          bus.src_hresp       = HRESP_ERROR;
        end
        DS_ERR2: begin
          bus.src_hready_resp = 1'b1;
          bus.src_hresp       = HRESP_ERROR;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ahbl_splitter.sv
module tb_ahbl_splitter;
  import ahbl_splitter_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  ahbl_splitter_if #(.N_PORTS(2), .W_ADDR(32), .W_DATA(32)) bus ();

  ahbl_splitter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Single-master system: the bus HREADY is the splitter's own response.
  assign bus.src_hready = bus.src_hready_resp;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rsp();
    return {62'd0, bus.src_hready_resp, bus.src_hresp};
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.src_haddr       = '0;
    bus.src_hwrite      = 1'b0;
    bus.src_htrans      = HTRANS_IDLE;
    bus.src_hsize       = 3'b010;
    bus.src_hburst      = 3'b000;
    bus.src_hprot       = 4'b0011;
    bus.src_hmastlock   = 1'b0;
    bus.src_hwdata      = '0;
    bus.dst_hready_resp = 2'b11;
    bus.dst_hresp       = 2'b00;
    bus.dst_hrdata      = {32'hdead_beef, 32'h1111_1111};

    // Reset state
    #12;
    check("reset_rsp", rsp(), 64'h2);
    check("reset_rdata", bus.src_hrdata, 64'h0);
    check("reset_sel_d", dut.sel_d, 64'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Mapped read to slave 1
    bus.src_haddr  = 32'h2000_0010;
    bus.src_htrans = HTRANS_NONSEQ;
    #1;
    check("rd_dst_htrans", bus.dst_htrans, 64'h8);
    check("rd_dst_haddr", bus.dst_haddr, {32'h2000_0010, 32'h2000_0010});
    tick();
    bus.src_htrans = HTRANS_IDLE;
    #1;
    check("rd_rdata", bus.src_hrdata, 64'hdead_beef);
    check("rd_rsp", rsp(), 64'h2);

    // Write to slave 0 with 3 wait states, next address held meanwhile
    bus.src_haddr  = 32'h0000_0004;
    bus.src_hwrite = 1'b1;
    bus.src_htrans = HTRANS_NONSEQ;
    #1;
    check("wr_dst_htrans", bus.dst_htrans, 64'h2);
    tick();
    bus.dst_hready_resp = 2'b10;
    bus.src_hwdata      = 32'hcafe_f00d;
    bus.src_haddr       = 32'h2000_0000;
    bus.src_hwrite      = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("ws_rsp", rsp(), 64'h0);
      check("ws_sel_d", dut.sel_d, 64'h1);
      check("ws_dst_hready", bus.dst_hready, 64'h0);
      check("ws_dst_hwdata", bus.dst_hwdata, {32'hcafe_f00d, 32'hcafe_f00d});
      tick();
    end
    bus.dst_hready_resp = 2'b11;
    #1;
    check("ws_done_rsp", rsp(), 64'h2);
    check("ws_done_sel_d", dut.sel_d, 64'h1);
    tick();
    bus.src_htrans = HTRANS_IDLE;
    #1;
    check("ws_next_sel_d", dut.sel_d, 64'h2);
    check("ws_next_rdata", bus.src_hrdata, 64'hdead_beef);

    // Unmapped single transfer
    bus.src_haddr  = 32'h5000_0000;
    bus.src_htrans = HTRANS_NONSEQ;
    #1;
    check("um_dst_htrans", bus.dst_htrans, 64'h0);
    tick();
    bus.src_htrans = HTRANS_IDLE;
    #1;
    check("um_err1", rsp(), 64'h1);
    check("um_err1_rdata", bus.src_hrdata, 64'h0);
    tick();
    check("um_err2", rsp(), 64'h3);
    tick();
    check("um_idle", rsp(), 64'h2);

    // Back-to-back unmapped, second address presented during ERR2
    bus.src_htrans = HTRANS_NONSEQ;
    tick();
    bus.src_htrans = HTRANS_IDLE;
    #1;
    check("bb_err1a", rsp(), 64'h1);
    tick();
    bus.src_haddr  = 32'h5000_0004;
    bus.src_htrans = HTRANS_NONSEQ;
    #1;
    check("bb_err2a", rsp(), 64'h3);
    tick();
    bus.src_htrans = HTRANS_IDLE;
    #1;
    check("bb_err1b", rsp(), 64'h1);
    tick();
    check("bb_err2b", rsp(), 64'h3);
    tick();
    check("bb_okay", rsp(), 64'h2);

    // BUSY to an unmapped address: OKAY, no error sequence
    bus.src_htrans = HTRANS_BUSY;
    #1;
    check("busy_dst_htrans", bus.dst_htrans, 64'h0);
    tick();
    bus.src_htrans = HTRANS_IDLE;
    #1;
    check("busy_rsp", rsp(), 64'h2);
    tick();
    check("busy_rsp2", rsp(), 64'h2);

    // Ping-pong slave 0 then slave 1, then a SEQ to slave 1
    bus.src_haddr  = 32'h0000_0008;
    bus.src_htrans = HTRANS_NONSEQ;
    #1;
    check("pp_dst_htrans0", bus.dst_htrans, 64'h2);
    tick();
    bus.src_haddr = 32'h2000_0008;
    #1;
    check("pp_rdata0", bus.src_hrdata, 64'h1111_1111);
    check("pp_dst_htrans1", bus.dst_htrans, 64'h8);
    tick();
    bus.src_haddr  = 32'h2000_000c;
    bus.src_htrans = HTRANS_SEQ;
    #1;
    check("pp_rdata1", bus.src_hrdata, 64'hdead_beef);
    check("pp_rsp1", rsp(), 64'h2);
    check("seq_dst_htrans", bus.dst_htrans, 64'hc);
    tick();
    bus.src_htrans = HTRANS_IDLE;
    #1;
    check("seq_rdata", bus.src_hrdata, 64'hdead_beef);
    tick();

    // Slave 0 two-cycle ERROR passes through
    bus.src_haddr  = 32'h0000_0000;
    bus.src_htrans = HTRANS_NONSEQ;
    tick();
    bus.src_htrans      = HTRANS_IDLE;
    bus.dst_hready_resp = 2'b10;
    bus.dst_hresp       = 2'b01;
    #1;
    check("serr_1", rsp(), 64'h1);
    tick();
    bus.dst_hready_resp = 2'b11;
    #1;
    check("serr_2", rsp(), 64'h3);
    tick();
    bus.dst_hresp = 2'b00;
    #1;
    check("serr_done", rsp(), 64'h2);

    // Async reset in ERR1
    bus.src_haddr  = 32'h5000_0000;
    bus.src_htrans = HTRANS_NONSEQ;
    tick();
    bus.src_htrans = HTRANS_IDLE;
    #1;
    check("rst_pre_err1", rsp(), 64'h1);
    rst_n = 1'b0;
    #1;
    check("rst_async_rsp", rsp(), 64'h2);
    check("rst_async_rdata", bus.src_hrdata, 64'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_after_rsp", rsp(), 64'h2);
    check("rst_after_sel_d", dut.sel_d, 64'h0);
    tick();
    check("rst_after_rsp2", rsp(), 64'h2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
